// File: rtl/memory_cycle.sv
// Memory stage of the 5-stage RISC-V pipeline: word-addressed data memory
// with read-before-write ordering, followed by the M/W pipeline register.
module memory_cycle #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALUResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_idx;
  logic              mem_we;
  logic [31:0]       rd_data;
  logic              unused_addr_bits;

  logic        reg_write_q,  reg_write_d;
  logic        result_src_q, result_src_d;
  logic [4:0]  rd_q,         rd_d;
  logic [31:0] pc_plus4_q,   pc_plus4_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] read_data_q,  read_data_d;

  // Byte-offset bits and bits above the array size are dropped, so
  // addresses alias modulo 4*DEPTH bytes.
  assign mem_idx          = ALUResultM[ADDR_W+1:2];
  assign unused_addr_bits = ^{ALUResultM[31:ADDR_W+2], ALUResultM[1:0]};

  assign mem_we  = MemWriteM & ~rst;
  assign rd_data = mem_q[mem_idx];

  // Memory has no reset: contents survive rst, and stores are gated off while it is high.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= WriteDataM;
    end
  end

  always_comb begin
    reg_write_d  = RegWriteM;
    result_src_d = ResultSrcM;
    rd_d         = RD_M;
    pc_plus4_d   = PCPlus4M;
    alu_result_d = ALUResultM;
    read_data_d  = rd_data;
  end

  // The read data captured here is the pre-store word when a store hits the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= 5'd0;
      pc_plus4_q   <= 32'h0;
      alu_result_q <= 32'h0;
      read_data_q  <= 32'h0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
    end
  end

  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign RD_W       = rd_q;
  assign PCPlus4W   = pc_plus4_q;
  assign ALUResultW = alu_result_q;
  assign ReadDataW  = read_data_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: stimulus pushes hand-computed expected
// W-stage values, and a monitor pops and compares one entry per clock edge.
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALUResultM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string       tag;
    logic        regw;
    logic        rsrc;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    bit          chkRdata;
  } exp_t;

  exp_t expQ[$];

  memory_cycle #(.DEPTH(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RD_M       (RD_M),
    .PCPlus4M   (PCPlus4M),
    .WriteDataM (WriteDataM),
    .ALUResultM (ALUResultM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RD_W       (RD_W),
    .PCPlus4W   (PCPlus4W),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkZeros(input string name);
    checkOutput({name, ".RegWriteW"},  {31'd0, RegWriteW},  32'h0);
    checkOutput({name, ".ResultSrcW"}, {31'd0, ResultSrcW}, 32'h0);
    checkOutput({name, ".RD_W"},       {27'd0, RD_W},       32'h0);
    checkOutput({name, ".PCPlus4W"},   PCPlus4W,            32'h0);
    checkOutput({name, ".ALUResultW"}, ALUResultW,          32'h0);
    checkOutput({name, ".ReadDataW"},  ReadDataW,           32'h0);
  endtask

  // Drives one instruction on the falling edge and records what the W outputs must show after the next rising edge.
  task automatic applyStimulus(input string tag, input logic regw, input logic memw, input logic rsrc,
                               input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wdata,
                               input logic [31:0] alu, input logic [31:0] expRdata, input bit chkRdata);
    exp_t e;
    @(negedge clk);
    RegWriteM  = regw;
    MemWriteM  = memw;
    ResultSrcM = rsrc;
    RD_M       = rd;
    PCPlus4M   = pc;
    WriteDataM = wdata;
    ALUResultM = alu;
    e.tag = tag; e.regw = regw; e.rsrc = rsrc; e.rd = rd;
    e.pc = pc; e.alu = alu; e.rdata = expRdata; e.chkRdata = chkRdata;
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    int budget;
    @(negedge clk);
    RegWriteM = 1'b0;
    MemWriteM = 1'b0;
    budget = 0;
    while (expQ.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    assertCount++;
    if (expQ.size() > 0) begin
      failCount++;
      $display("[TB] FAIL %s drain: %0d entries left, expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.tag, ".RegWriteW"},  {31'd0, RegWriteW},  {31'd0, e.regw});
      checkOutput({e.tag, ".ResultSrcW"}, {31'd0, ResultSrcW}, {31'd0, e.rsrc});
      checkOutput({e.tag, ".RD_W"},       {27'd0, RD_W},       {27'd0, e.rd});
      checkOutput({e.tag, ".PCPlus4W"},   PCPlus4W,            e.pc);
      checkOutput({e.tag, ".ALUResultW"}, ALUResultW,          e.alu);
      if (e.chkRdata) checkOutput({e.tag, ".ReadDataW"}, ReadDataW, e.rdata);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Power-on reset with arbitrary non-zero inputs.
    rst        = 1'b1;
    RegWriteM  = 1'b1;
    MemWriteM  = 1'b1;
    ResultSrcM = 1'b1;
    RD_M       = 5'd17;
    PCPlus4M   = 32'h1234_5678;
    WriteDataM = 32'h0BAD_F00D;
    ALUResultM = 32'h0000_0020;
    #2;
    checkZeros("por");
    repeat (3) begin
      @(posedge clk); #1;
      checkZeros("por_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    MemWriteM = 1'b0;
    RegWriteM = 1'b0;

    // Store then load.
    applyStimulus("st1",   1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h10, 32'h0, 1'b0);
    applyStimulus("ld1",   1'b1, 1'b0, 1'b1, 5'd5, 32'h104, 32'h0,         32'h10, 32'hDEAD_BEEF, 1'b1);

    // Read-before-write on the same index.
    applyStimulus("st11",  1'b0, 1'b1, 1'b0, 5'd0, 32'h108, 32'h1111_1111, 32'h10, 32'hDEAD_BEEF, 1'b1);
    applyStimulus("st22",  1'b0, 1'b1, 1'b0, 5'd0, 32'h10C, 32'h2222_2222, 32'h10, 32'h1111_1111, 1'b1);
    applyStimulus("ld22",  1'b1, 1'b0, 1'b1, 5'd6, 32'h110, 32'h0,         32'h10, 32'h2222_2222, 1'b1);

    // Back-to-back stores to one index: last wins.
    applyStimulus("stA",   1'b0, 1'b1, 1'b0, 5'd0, 32'h114, 32'hAAAA_AAAA, 32'h14, 32'h0, 1'b0);
    applyStimulus("stB",   1'b0, 1'b1, 1'b0, 5'd0, 32'h118, 32'hBBBB_BBBB, 32'h14, 32'hAAAA_AAAA, 1'b1);
    applyStimulus("ldB",   1'b1, 1'b0, 1'b1, 5'd7, 32'h11C, 32'h0,         32'h14, 32'hBBBB_BBBB, 1'b1);

    // Aliasing modulo 4 KiB and ignored byte offset.
    applyStimulus("stCafe", 1'b0, 1'b1, 1'b0, 5'd0, 32'h120, 32'hCAFE_0001, 32'h0000_1000, 32'h0, 1'b0);
    applyStimulus("ldA0",   1'b1, 1'b0, 1'b1, 5'd8, 32'h124, 32'h0,         32'h0000_0000, 32'hCAFE_0001, 1'b1);
    applyStimulus("ldA3",   1'b1, 1'b0, 1'b1, 5'd9, 32'h128, 32'h0,         32'h0000_0003, 32'hCAFE_0001, 1'b1);
    applyStimulus("ldAhi",  1'b1, 1'b0, 1'b1, 5'd10, 32'h12C, 32'h0,        32'hFFFF_F000, 32'hCAFE_0001, 1'b1);

    // Top word of the array, reached through an aliased address.
    applyStimulus("stTop", 1'b0, 1'b1, 1'b0, 5'd0,  32'h130, 32'h1234_5678, 32'h0000_0FFC, 32'h0, 1'b0);
    applyStimulus("ldTop", 1'b1, 1'b0, 1'b1, 5'd31, 32'h134, 32'h0,         32'h0000_7FFC, 32'h1234_5678, 1'b1);

    // Pass-through stream.
    applyStimulus("pt0", 1'b1, 1'b0, 1'b0, 5'd1, 32'd4,  32'h0, 32'd7,  32'h0, 1'b0);
    applyStimulus("pt1", 1'b1, 1'b0, 1'b0, 5'd2, 32'd8,  32'h0, 32'd8,  32'h0, 1'b0);
    applyStimulus("pt2", 1'b0, 1'b0, 1'b0, 5'd3, 32'd12, 32'h0, 32'd9,  32'h0, 1'b0);
    applyStimulus("pt3", 1'b1, 1'b0, 1'b1, 5'd4, 32'd16, 32'h0, 32'd10, 32'h0, 1'b0);
    waitDrain("stream");

    // Asynchronous reset between edges after non-zero outputs were captured.
    applyStimulus("preRst", 1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0, 32'h0000_0040, 32'h0, 1'b0);
    waitDrain("preRst");
    #2;
    rst = 1'b1;
    #1;
    checkZeros("async_rst");

    // Store attempted under reset must not land.
    MemWriteM  = 1'b1;
    RegWriteM  = 1'b1;
    ALUResultM = 32'h20;
    WriteDataM = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      checkZeros("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    MemWriteM = 1'b0;

    applyStimulus("stA5",  1'b0, 1'b1, 1'b0, 5'd0,  32'h200, 32'hA5A5_A5A5, 32'h20, 32'h0, 1'b0);
    waitDrain("stA5");
    @(negedge clk);
    rst        = 1'b1;
    MemWriteM  = 1'b1;
    ALUResultM = 32'h20;
    WriteDataM = 32'h0;
    @(posedge clk); #1;
    checkZeros("rst_store");
    @(negedge clk);
    rst = 1'b0;
    MemWriteM = 1'b0;
    applyStimulus("ldA5",  1'b1, 1'b0, 1'b1, 5'd12, 32'h204, 32'h0, 32'h20, 32'hA5A5_A5A5, 1'b1);
    waitDrain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
